// File: rtl/axi_lite_mem_resp.sv
// AXI4-Lite responder backed by a small byte-writable register memory.
// Define AXI_LITE_MEM_RESP_DECERR_EN to answer out-of-range addresses with DECERR instead of aliasing.
package axi_lite_mem_resp_pkg;
  typedef struct packed {
    logic [31:0] addr;
    logic [2:0]  prot;
  } ax_chan_t;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  strb;
  } w_chan_t;

  typedef struct packed {
    logic [1:0] resp;
  } b_chan_t;

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  resp;
  } r_chan_t;

  typedef struct packed {
    ax_chan_t aw;
    logic     aw_valid;
    w_chan_t  w;
    logic     w_valid;
    logic     b_ready;
    ax_chan_t ar;
    logic     ar_valid;
    logic     r_ready;
  } req_t;

  typedef struct packed {
    logic    aw_ready;
    logic    w_ready;
    b_chan_t b;
    logic    b_valid;
    logic    ar_ready;
    r_chan_t r;
    logic    r_valid;
  } resp_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_DECERR = 2'b11;
endpackage

// Handshake rule on every channel: a transfer happens on a rising edge where valid
// and ready are both high; a responder holds valid and payload stable until then.
module axi_lite_mem_resp #(
  parameter int unsigned AddrWidth = 32,
  parameter int unsigned DataWidth = 32,
  parameter int unsigned NumWords  = 16,
  parameter type req_t  = axi_lite_mem_resp_pkg::req_t,
  parameter type resp_t = axi_lite_mem_resp_pkg::resp_t
) (
  input  logic  clk_i,
  input  logic  rst_ni,
  input  req_t  slv_req_i,
  output resp_t slv_resp_o
);
  import axi_lite_mem_resp_pkg::*;

  localparam int unsigned StrbW = DataWidth / 8;
  localparam int unsigned OffW  = $clog2(StrbW);
  localparam int unsigned IdxW  = $clog2(NumWords);

  typedef enum logic { W_IDLE, W_RESP } w_state_e;
  typedef enum logic { R_IDLE, R_RESP } r_state_e;

  w_state_e w_state_q, w_state_d;
  r_state_e r_state_q, r_state_d;

  logic [DataWidth-1:0] mem_q [NumWords];
  logic [DataWidth-1:0] r_data_q;
  logic [1:0]           r_resp_q;
  logic [1:0]           b_resp_q;

  logic            aw_hs, b_hs, ar_hs, r_hs;
  logic            w_in_range, r_in_range;
  logic [IdxW-1:0] w_idx, r_idx;

  assign w_idx = slv_req_i.aw.addr[OffW +: IdxW];
  assign r_idx = slv_req_i.ar.addr[OffW +: IdxW];

`ifdef AXI_LITE_MEM_RESP_DECERR_EN
  assign w_in_range = (slv_req_i.aw.addr[AddrWidth-1:OffW+IdxW] == '0);
  assign r_in_range = (slv_req_i.ar.addr[AddrWidth-1:OffW+IdxW] == '0);
`else
  assign w_in_range = 1'b1;
  assign r_in_range = 1'b1;
`endif

  // Protection bits and byte offsets carry no meaning for a word memory.
  logic unused_req_bits;
  assign unused_req_bits = ^{slv_req_i.aw.prot, slv_req_i.ar.prot,
                             slv_req_i.aw.addr, slv_req_i.ar.addr};

  // AW and W are only ever taken together.
  assign aw_hs = (w_state_q == W_IDLE) && slv_req_i.aw_valid && slv_req_i.w_valid;
  assign b_hs  = (w_state_q == W_RESP) && slv_req_i.b_ready;
  assign ar_hs = (r_state_q == R_IDLE) && slv_req_i.ar_valid;
  assign r_hs  = (r_state_q == R_RESP) && slv_req_i.r_ready;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      w_state_q <= W_IDLE;
      r_state_q <= R_IDLE;
    end else begin
      w_state_q <= w_state_d;
      r_state_q <= r_state_d;
    end
  end

  always_comb begin
    w_state_d = w_state_q;
    r_state_d = r_state_q;
    if (aw_hs) w_state_d = W_RESP;
    if (b_hs)  w_state_d = W_IDLE;
    if (ar_hs) r_state_d = R_RESP;
    if (r_hs)  r_state_d = R_IDLE;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NumWords; i++) mem_q[i] <= '0;
    end else if (aw_hs && w_in_range) begin
      for (int b = 0; b < StrbW; b++) begin
        if (slv_req_i.w.strb[b]) mem_q[w_idx][8*b +: 8] <= slv_req_i.w.data[8*b +: 8];
      end
    end
  end

  // The read captures mem_q before any same-edge write lands: read-before-write.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_data_q <= '0;
      r_resp_q <= RESP_OKAY;
      b_resp_q <= RESP_OKAY;
    end else begin
      if (ar_hs) begin
        r_data_q <= r_in_range ? mem_q[r_idx] : '0;
        r_resp_q <= r_in_range ? RESP_OKAY : RESP_DECERR;
      end
      if (aw_hs) b_resp_q <= w_in_range ? RESP_OKAY : RESP_DECERR;
    end
  end

  always_comb begin
    slv_resp_o          = '0;
    slv_resp_o.aw_ready = aw_hs;
    slv_resp_o.w_ready  = aw_hs;
    slv_resp_o.b_valid  = (w_state_q == W_RESP);
    slv_resp_o.b.resp   = b_resp_q;
    slv_resp_o.ar_ready = (r_state_q == R_IDLE);
    slv_resp_o.r_valid  = (r_state_q == R_RESP);
    slv_resp_o.r.data   = r_data_q;
    slv_resp_o.r.resp   = r_resp_q;
  end
endmodule

// File: tb/tb_axi_lite_mem_resp.sv
// Directed bench for axi_lite_mem_resp: vector table plus hand-written multi-cycle sequences.
module tb_axi_lite_mem_resp;
  import axi_lite_mem_resp_pkg::*;

  logic  clk;
  logic  rst_n;
  req_t  req;
  resp_t resp;

  int n_vec = 0;
  int n_err = 0;

  axi_lite_mem_resp dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .slv_req_i  (req),
    .slv_resp_o (resp)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          is_wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [31:0] exp_data;
    logic [1:0]  exp_resp;
  } vec_t;

  vec_t vecs[$];

`ifdef AXI_LITE_MEM_RESP_DECERR_EN
  localparam logic [1:0]  ALIAS_RESP   = 2'b11;
  localparam logic [31:0] ALIAS_WORD0  = 32'h5A5A5A5A;
  localparam logic [31:0] ALIAS_RDATA  = 32'h0;
`else
  localparam logic [1:0]  ALIAS_RESP   = 2'b00;
  localparam logic [31:0] ALIAS_WORD0  = 32'h77777777;
  localparam logic [31:0] ALIAS_RDATA  = 32'h77777777;
`endif

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    req = '0;
  endtask

  // driver tasks: request driven after a falling edge, sampled #1 later or on the next falling edge
  task automatic do_write(input string tag, input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, input logic [1:0] exp_resp);
    @(negedge clk);
    req.aw.addr  = addr;
    req.w.data   = data;
    req.w.strb   = strb;
    req.aw_valid = 1'b1;
    req.w_valid  = 1'b1;
    req.b_ready  = 1'b1;
    #1;
    check({tag, "_awready"}, resp.aw_ready, 1'b1);
    @(negedge clk);
    req.aw_valid = 1'b0;
    req.w_valid  = 1'b0;
    check({tag, "_bvalid"}, resp.b_valid, 1'b1);
    check({tag, "_bresp"}, resp.b.resp, exp_resp);
    @(negedge clk);
    check({tag, "_bdone"}, resp.b_valid, 1'b0);
  endtask

  task automatic do_read(input string tag, input logic [31:0] addr,
                         input logic [31:0] exp_data, input logic [1:0] exp_resp);
    @(negedge clk);
    req.ar.addr  = addr;
    req.ar_valid = 1'b1;
    req.r_ready  = 1'b1;
    #1;
    check({tag, "_arready"}, resp.ar_ready, 1'b1);
    @(negedge clk);
    req.ar_valid = 1'b0;
    check({tag, "_rvalid"}, resp.r_valid, 1'b1);
    check({tag, "_rdata"}, resp.r.data, exp_data);
    check({tag, "_rresp"}, resp.r.resp, exp_resp);
    @(negedge clk);
    check({tag, "_rdone"}, resp.r_valid, 1'b0);
  endtask

  initial begin
    // vector table; applied after the hand-written sequences below
    vecs.push_back('{1'b1, 32'h8,  32'hDEADBEEF, 4'hF, 32'h0,        2'b00});
    vecs.push_back('{1'b0, 32'h8,  32'h0,        4'h0, 32'hDEADBEEF, 2'b00});
    vecs.push_back('{1'b1, 32'h4,  32'h11223344, 4'hF, 32'h0,        2'b00});
    vecs.push_back('{1'b1, 32'h4,  32'hAABBCCDD, 4'h5, 32'h0,        2'b00});
    vecs.push_back('{1'b0, 32'h4,  32'h0,        4'h0, 32'h11BB33DD, 2'b00});
    vecs.push_back('{1'b1, 32'hC,  32'h12345678, 4'h0, 32'h0,        2'b00});
    vecs.push_back('{1'b0, 32'hC,  32'h0,        4'h0, 32'h0,        2'b00});
    vecs.push_back('{1'b1, 32'h3C, 32'hCAFEF00D, 4'hF, 32'h0,        2'b00});
    vecs.push_back('{1'b0, 32'h3C, 32'h0,        4'h0, 32'hCAFEF00D, 2'b00});
    vecs.push_back('{1'b0, 32'hB,  32'h0,        4'h0, 32'hDEADBEEF, 2'b00});
    vecs.push_back('{1'b0, 32'h10, 32'h0,        4'h0, 32'h0BADC0DE, 2'b00});
    vecs.push_back('{1'b0, 32'h14, 32'h0,        4'h0, 32'h13572468, 2'b00});
    vecs.push_back('{1'b1, 32'h40, 32'h77777777, 4'hF, 32'h0,        ALIAS_RESP});
    vecs.push_back('{1'b0, 32'h0,  32'h0,        4'h0, ALIAS_WORD0,  2'b00});
    vecs.push_back('{1'b0, 32'h40, 32'h0,        4'h0, ALIAS_RDATA,  ALIAS_RESP});

    // reset
    idle_inputs();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_bvalid", resp.b_valid, 1'b0);
    check("rst_rvalid", resp.r_valid, 1'b0);
    check("rst_arready", resp.ar_ready, 1'b1);
    check("rst_awready", resp.aw_ready, 1'b0);
    check("rst_rdata", resp.r.data, 32'h0);
    check("rst_rresp", resp.r.resp, 2'b00);
    check("rst_bresp", resp.b.resp, 2'b00);
    rst_n = 1'b1;

    // same-cycle read and write to word 0: read sees the old value
    @(negedge clk);
    req.ar.addr = 32'h0; req.ar_valid = 1'b1; req.r_ready = 1'b1;
    req.aw.addr = 32'h0; req.w.data = 32'h5A5A5A5A; req.w.strb = 4'hF;
    req.aw_valid = 1'b1; req.w_valid = 1'b1; req.b_ready = 1'b1;
    #1;
    check("rbw_arready", resp.ar_ready, 1'b1);
    check("rbw_awready", resp.aw_ready, 1'b1);
    @(negedge clk);
    idle_inputs(); req.b_ready = 1'b1; req.r_ready = 1'b1;
    check("rbw_rvalid", resp.r_valid, 1'b1);
    check("rbw_rdata_old", resp.r.data, 32'h0);
    check("rbw_bvalid", resp.b_valid, 1'b1);
    @(negedge clk);
    check("rbw_bdone", resp.b_valid, 1'b0);
    check("rbw_rdone", resp.r_valid, 1'b0);
    do_read("rbw_new", 32'h0, 32'h5A5A5A5A, 2'b00);

    // AW alone for three cycles, W joins in the fourth
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      req.aw.addr = 32'h10; req.w.data = 32'h0BADC0DE; req.w.strb = 4'hF;
      req.aw_valid = 1'b1; req.w_valid = 1'b0; req.b_ready = 1'b1;
      #1;
      check($sformatf("awonly_c%0d_awready", c), resp.aw_ready, 1'b0);
      check($sformatf("awonly_c%0d_wready", c), resp.w_ready, 1'b0);
    end
    @(negedge clk);
    req.w_valid = 1'b1;
    #1;
    check("awonly_c3_awready", resp.aw_ready, 1'b1);
    check("awonly_c3_bvalid", resp.b_valid, 1'b0);
    @(negedge clk);
    req.aw_valid = 1'b0; req.w_valid = 1'b0;
    check("awonly_c4_bvalid", resp.b_valid, 1'b1);
    @(negedge clk);

    // backpressure: responses held five cycles while stray requests are refused
    idle_inputs();
    req.aw.addr = 32'h14; req.w.data = 32'h13572468; req.w.strb = 4'hF;
    req.aw_valid = 1'b1; req.w_valid = 1'b1;
    req.ar.addr = 32'h10; req.ar_valid = 1'b1;
    @(negedge clk);
    for (int c = 0; c < 5; c++) begin
      req.aw.addr = 32'h10; req.w.data = 32'hFFFFFFFF;
      req.ar.addr = 32'h14;
      #1;
      check($sformatf("bp_c%0d_awready", c), resp.aw_ready, 1'b0);
      check($sformatf("bp_c%0d_arready", c), resp.ar_ready, 1'b0);
      check($sformatf("bp_c%0d_bvalid", c), resp.b_valid, 1'b1);
      check($sformatf("bp_c%0d_rvalid", c), resp.r_valid, 1'b1);
      check($sformatf("bp_c%0d_rdata", c), resp.r.data, 32'h0BADC0DE);
      check($sformatf("bp_c%0d_bresp", c), resp.b.resp, 2'b00);
      @(negedge clk);
    end
    idle_inputs(); req.b_ready = 1'b1; req.r_ready = 1'b1;
    #1;
    check("bp_release_arready_still_low", resp.ar_ready, 1'b0);
    @(negedge clk);
    check("bp_release_bvalid", resp.b_valid, 1'b0);
    check("bp_release_rvalid", resp.r_valid, 1'b0);
    check("bp_release_arready", resp.ar_ready, 1'b1);

    // table-driven vectors
    foreach (vecs[i]) begin
      if (vecs[i].is_wr)
        do_write($sformatf("vec%0d", i), vecs[i].addr, vecs[i].data, vecs[i].strb, vecs[i].exp_resp);
      else
        do_read($sformatf("vec%0d", i), vecs[i].addr, vecs[i].exp_data, vecs[i].exp_resp);
    end

    // reset in the middle of pending responses
    @(negedge clk);
    idle_inputs();
    req.aw.addr = 32'h18; req.w.data = 32'h24682468; req.w.strb = 4'hF;
    req.aw_valid = 1'b1; req.w_valid = 1'b1;
    req.ar.addr = 32'h10; req.ar_valid = 1'b1;
    @(negedge clk);
    idle_inputs();
    check("mid_bvalid_pending", resp.b_valid, 1'b1);
    check("mid_rvalid_pending", resp.r_valid, 1'b1);
    #1 rst_n = 1'b0;
    #1;
    check("mid_rst_bvalid", resp.b_valid, 1'b0);
    check("mid_rst_rvalid", resp.r_valid, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("mid_norelay_bvalid", resp.b_valid, 1'b0);
    check("mid_norelay_rvalid", resp.r_valid, 1'b0);
    do_read("mid_mem10", 32'h10, 32'h0, 2'b00);
    do_read("mid_mem8", 32'h8, 32'h0, 2'b00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
